// File: rtl/subtractor.sv
// Two-stage pipelined three-operand subtractor: result = i_a - i_b - i_c.
// Stage 1 captures the operands and stage 2 captures the result and the
// underflow flag. Both sides use valid/ready handshakes. o_count tallies
// the results taken by downstream and wraps at 16 bits.
module subtractor #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_underflow,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      o_count
);
    // Two extra bits hold the most negative case, 0 - 2*(2^WIDTH - 1), as a signed value.
    localparam int EXT_W = WIDTH + 2;

    // Signed difference of the three unsigned operands, zero-extended first.
    function automatic logic signed [EXT_W-1:0] diff_ext(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic signed [EXT_W-1:0] ea;
        logic signed [EXT_W-1:0] eb;
        logic signed [EXT_W-1:0] ec;
        ea = $signed({2'b00, a});
        eb = $signed({2'b00, b});
        ec = $signed({2'b00, c});
        return ea - eb - ec;
    endfunction

    // Result presented downstream: low WIDTH bits, or zero when clamping an underflow.
    function automatic logic [WIDTH-1:0] select_result(
        input logic [WIDTH-1:0] wrapped,
        input logic             under
    );
        logic [WIDTH-1:0] res;
        if ((SATURATE == 1'b1) && under) begin
            res = {WIDTH{1'b0}};
        end else begin
            res = wrapped;
        end
        return res;
    endfunction

    logic [WIDTH-1:0]        s1_a_r;
    logic [WIDTH-1:0]        s1_b_r;
    logic [WIDTH-1:0]        s1_c_r;
    logic                    s1_valid_r;
    logic [WIDTH-1:0]        s2_diff_r;
    logic                    s2_under_r;
    logic                    s2_valid_r;
    logic [15:0]             count_r;

    logic                    s1_adv_s;
    logic                    ready_s;
    logic                    in_hs_s;
    logic                    out_hs_s;
    logic signed [EXT_W-1:0] d_s;
    logic                    under_s;
    logic [WIDTH-1:0]        result_s;

    // Handshake decode and the stage-2 input arithmetic.
    always_comb begin
        s1_adv_s = 1'b0;
        ready_s  = 1'b0;
        in_hs_s  = 1'b0;
        out_hs_s = 1'b0;
        d_s      = {EXT_W{1'b0}};
        under_s  = 1'b0;
        result_s = {WIDTH{1'b0}};

        // Stage 1 moves forward whenever stage 2 is empty or is being drained.
        s1_adv_s = s1_valid_r & (~s2_valid_r | i_ready);
        // Ready is forced low during reset so that nothing is accepted then.
        ready_s  = i_rst_n & (~s1_valid_r | s1_adv_s);
        in_hs_s  = i_valid & ready_s;
        out_hs_s = i_rst_n & s2_valid_r & i_ready;

        d_s      = diff_ext(s1_a_r, s1_b_r, s1_c_r);
        under_s  = (d_s < $signed({EXT_W{1'b0}}));
        result_s = select_result(d_s[WIDTH-1:0], under_s);
    end

    // Stage 1: capture operands on input handshake, empty when drained without refill.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_c_r     <= {WIDTH{1'b0}};
        end else if (in_hs_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= i_a;
            s1_b_r     <= i_b;
            s1_c_r     <= i_c;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: capture result and flag from stage 1, empty when taken without refill.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_r <= 1'b0;
            s2_diff_r  <= {WIDTH{1'b0}};
            s2_under_r <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_diff_r  <= result_s;
            s2_under_r <= under_s;
        end else if (out_hs_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Delivered-result counter; wraps naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_r <= 16'h0000;
        end else if (out_hs_s) begin
            count_r <= count_r + 16'h0001;
        end
    end

    assign o_ready     = ready_s;
    assign o_valid     = s2_valid_r & i_rst_n;
    assign o_diff      = s2_diff_r;
    assign o_underflow = s2_under_r;
    assign o_count     = count_r;

endmodule
